// File: rtl/vga_term_pkg.sv
// Shared types and constants for the text-terminal write controller.
// Holds the FSM state enum, control-character codes, geometry defaults and
// a printable-range helper used by the put path.
package vga_term_pkg;

  typedef enum logic [1:0] {IDLE, CLRLINE, CLRALL} state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  localparam int COLS          = 70;
  localparam int ROWS          = 30;
  localparam int STRIDE_LOG2   = 7;
  // 128 chars per RAM row / 4 chars per 32-bit word
  localparam int WORDS_PER_ROW = 32;
  localparam int NUM_LANES     = 4;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= CH_SP) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/vga_term_ctrl_if.sv
// CPU character stream plus video RAM write bus.
//   master : CPU / RAM side  (drives ch_valid, ch_data, clr_req)
//   slave  : controller side (drives ch_ready and the wr_* write port)
interface vga_term_ctrl_if;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        clr_req;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output ch_valid, ch_data, clr_req,
    input  ch_ready, wr_en, wr_addr, wr_data, wr_be
  );

  modport slave (
    input  ch_valid, ch_data, clr_req,
    output ch_ready, wr_en, wr_addr, wr_data, wr_be
  );
endinterface

// File: rtl/vga_term_addr.sv
// Combinational cursor-to-RAM address map.
//   row, col, offset -> phys_row (row+offset mod ROWS), word address, lane enables.
// The modulo is a single compare-subtract: both operands are < ROWS, so the
// sum is below 2*ROWS and one subtraction suffices.
module vga_term_addr
  import vga_term_pkg::*;
#(
  parameter int ROWS_P        = ROWS,
  parameter int STRIDE_LOG2_P = STRIDE_LOG2
) (
  input  logic [4:0] row,
  input  logic [6:0] col,
  input  logic [4:0] offset,
  output logic [4:0] phys_row,
  output logic [9:0] addr,
  output logic [3:0] be
);

  logic [5:0]  sum;
  logic [5:0]  sum_wrap;
  logic [11:0] char_idx;

  assign sum      = {1'b0, row} + {1'b0, offset};
  assign sum_wrap = sum - 6'(ROWS_P);
  assign phys_row = (sum >= 6'(ROWS_P)) ? sum_wrap[4:0] : sum[4:0];
  assign char_idx = (12'(phys_row) << STRIDE_LOG2_P) + 12'(col);
  assign addr     = char_idx[11:2];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign be[l] = (char_idx[1:0] == 2'(l));
  end

endmodule

// File: rtl/vga_term_ctrl.sv
// Text-terminal write controller.
//   clkin, clrn          : clock, async active-low reset
//   bus (slave)          : ch_valid/ch_data/ch_ready character stream, clr_req,
//                          registered video RAM write port wr_en/addr/data/be
//   cursor_x, cursor_y   : logical cursor position
//   row_offset           : physical RAM row shown as logical row 0
//   busy                 : high outside IDLE
// Scrolling rotates row_offset instead of moving RAM contents; only the
// newly exposed bottom row is cleared.
module vga_term_ctrl
  import vga_term_pkg::*;
#(
  parameter int COLS_P        = COLS,
  parameter int ROWS_P        = ROWS,
  parameter int STRIDE_LOG2_P = STRIDE_LOG2
) (
  input  logic            clkin,
  input  logic            clrn,
  vga_term_ctrl_if.slave  bus,
  output logic [6:0]      cursor_x,
  output logic [4:0]      cursor_y,
  output logic [4:0]      row_offset,
  output logic            busy
);

  localparam logic [6:0] X_LAST    = 7'(COLS_P - 1);
  localparam logic [4:0] Y_LAST    = 5'(ROWS_P - 1);
  localparam logic [9:0] CNT_LINE  = 10'(WORDS_PER_ROW - 1);
  localparam logic [9:0] CNT_ALL   = 10'(ROWS_P * WORDS_PER_ROW - 1);

  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n;
  logic [6:0]  x_n;
  logic [4:0]  y_n, off_n;
  logic        we_n;
  logic [9:0]  wa_n;
  logic [31:0] wd_n;
  logic [3:0]  be_n;
  logic        nl;

  logic [6:0]  a_col;
  logic [4:0]  a_phys;
  logic [9:0]  a_addr;
  logic [3:0]  a_be;

  // Backspace writes at the column it moves to; every other write is at the cursor.
  assign a_col = (bus.ch_data == CH_BS) ? cursor_x - 7'd1 : cursor_x;

  vga_term_addr #(.ROWS_P(ROWS_P), .STRIDE_LOG2_P(STRIDE_LOG2_P)) u_addr (
    .row      (cursor_y),
    .col      (a_col),
    .offset   (row_offset),
    .phys_row (a_phys),
    .addr     (a_addr),
    .be       (a_be)
  );

  assign bus.ch_ready = (state == IDLE) && !bus.clr_req;
  assign busy         = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = cursor_x;
    y_n     = cursor_y;
    off_n   = row_offset;
    we_n    = 1'b0;
    wa_n    = '0;
    wd_n    = '0;
    be_n    = '0;
    nl      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_n = CLRALL;
          cnt_n   = '0;
          x_n     = '0;
          y_n     = '0;
          off_n   = '0;
        end else if (bus.ch_valid) begin
          if (is_print(bus.ch_data)) begin
            we_n = 1'b1;
            wa_n = a_addr;
            be_n = a_be;
            wd_n = {NUM_LANES{bus.ch_data}};
            if (cursor_x < X_LAST) x_n = cursor_x + 7'd1;
            else                   nl  = 1'b1;
          end else if (bus.ch_data == CH_CR) begin
            x_n = '0;
          end else if (bus.ch_data == CH_LF) begin
            nl = 1'b1;
          end else if (bus.ch_data == CH_BS && cursor_x != '0) begin
            x_n  = cursor_x - 7'd1;
            we_n = 1'b1;
            wa_n = a_addr;
            be_n = a_be;
            wd_n = {NUM_LANES{CH_SP}};
          end
        end

        // Wrap and explicit LF share this path, so a wrap on the last row
        // scrolls exactly once.
        if (nl) begin
          x_n = '0;
          if (cursor_y < Y_LAST) begin
            y_n = cursor_y + 5'd1;
          end else begin
            off_n   = (row_offset == Y_LAST) ? 5'd0 : row_offset + 5'd1;
            state_n = CLRLINE;
            cnt_n   = '0;
          end
        end
      end

      // cursor_y is ROWS-1 here, so a_phys resolves to the old row_offset:
      // the row that just became the bottom line.
      CLRLINE: begin
        we_n = 1'b1;
        wa_n = {a_phys, cnt[4:0]};
        be_n = 4'hF;
        if (cnt == CNT_LINE) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end

      CLRALL: begin
        we_n = 1'b1;
        wa_n = cnt;
        be_n = 4'hF;
        if (cnt == CNT_ALL) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 10'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      state       <= CLRALL;
      cnt         <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      row_offset  <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_be   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cursor_x    <= x_n;
      cursor_y    <= y_n;
      row_offset  <= off_n;
      bus.wr_en   <= we_n;
      bus.wr_addr <= wa_n;
      bus.wr_data <= wd_n;
      bus.wr_be   <= be_n;
    end
  end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl: power-up clear, put/wrap, scroll with
// line clear, backspace, discard codes, clear request and mid-clear reset.
module tb_vga_term_ctrl;
  import vga_term_pkg::*;

  logic       clkin = 1'b0;
  logic       clrn  = 1'b1;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic [4:0] row_offset;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  vga_term_ctrl_if bus ();

  vga_term_ctrl dut (
    .clkin      (clkin),
    .clrn       (clrn),
    .bus        (bus),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .row_offset (row_offset),
    .busy       (busy)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Present one character and hold it through the accepting edge.
  task automatic send(input logic [7:0] c);
    int t;
    @(negedge clkin);
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    t = 0;
    while (!bus.ch_ready && t < 2000) begin
      @(negedge clkin);
      t++;
    end
    if (!bus.ch_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clkin);
    #1 bus.ch_valid = 1'b0;
  endtask

  // Collect one burst of clear writes and check it is base, base+1, ...
  task automatic wait_clear(input int base, input int expn, input string tag);
    int n, bad, rdy, t;
    n = 0; bad = 0; rdy = 0; t = 0;
    while (t < 3000) begin
      @(negedge clkin);
      t++;
      if (bus.wr_en) begin
        if (bus.wr_addr !== 10'(base + n) || bus.wr_be !== 4'hF || bus.wr_data !== 32'd0)
          bad++;
        if (bus.ch_ready) rdy++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    chk({tag, "_count"}, 32'(n), 32'(expn));
    chk({tag, "_seq"},   32'(bad), 32'd0);
    // registered writes trail the state: only the final write coincides with IDLE
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    bus.clr_req  = 1'b0;
    #2 clrn = 1'b0;
    #10;
    chk("rst_wr_en",  32'(bus.wr_en),   32'd0);
    chk("rst_wr_addr",32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data",bus.wr_data,      32'd0);
    chk("rst_wr_be",  32'(bus.wr_be),   32'd0);
    chk("rst_busy",   32'(busy),        32'd1);
    chk("rst_ready",  32'(bus.ch_ready),32'd0);
    chk("rst_cur",    32'({cursor_x, cursor_y, row_offset}), 32'd0);

    @(negedge clkin) clrn = 1'b1;
    wait_clear(0, 960, "pwrup_clr");
    chk("idle_busy",  32'(busy),         32'd0);
    chk("idle_ready", 32'(bus.ch_ready), 32'd1);

    send(8'h41);
    @(negedge clkin);
    chk("a_wr_en",  32'(bus.wr_en),   32'd1);
    chk("a_addr",   32'(bus.wr_addr), 32'd0);
    chk("a_be",     32'(bus.wr_be),   32'h1);
    chk("a_data",   bus.wr_data,      32'h41414141);
    chk("a_cur_x",  32'(cursor_x),    32'd1);

    send(CH_CR);
    @(negedge clkin);
    chk("cr_nowr",  32'(bus.wr_en), 32'd0);
    chk("cr_cur_x", 32'(cursor_x),  32'd0);

    repeat (69) send(8'h42);
    send(8'h42);
    @(negedge clkin);
    chk("b70_addr", 32'(bus.wr_addr), 32'd17);
    chk("b70_be",   32'(bus.wr_be),   32'h2);
    chk("b70_cur",  32'({cursor_x, cursor_y}), 32'({7'd0, 5'd1}));

    send(8'h43);
    @(negedge clkin);
    chk("c_addr", 32'(bus.wr_addr), 32'd32);
    chk("c_be",   32'(bus.wr_be),   32'h1);
    chk("c_data", bus.wr_data,      32'h43434343);

    repeat (28) send(CH_LF);
    @(negedge clkin);
    chk("lf_cur_y", 32'(cursor_y),   32'd29);
    chk("lf_off",   32'(row_offset), 32'd0);
    chk("lf_nowr",  32'(bus.wr_en),  32'd0);

    send(CH_LF);
    @(negedge clkin);
    chk("scr_off",   32'(row_offset), 32'd1);
    chk("scr_cur_y", 32'(cursor_y),   32'd29);
    chk("scr_busy",  32'(busy),       32'd1);
    wait_clear(0, 32, "scr_clr");

    send(8'h44);
    @(negedge clkin);
    chk("d_addr", 32'(bus.wr_addr), 32'd0);
    chk("d_be",   32'(bus.wr_be),   32'h1);
    chk("d_cur_x",32'(cursor_x),    32'd1);

    // wrap on the last row: one scroll, offset 1 -> 2, clear physical row 1
    repeat (68) send(8'h45);
    send(8'h46);
    @(negedge clkin);
    chk("f_addr", 32'(bus.wr_addr), 32'd17);
    chk("f_be",   32'(bus.wr_be),   32'h2);
    chk("f_data", bus.wr_data,      32'h46464646);
    chk("f_off",  32'(row_offset),  32'd2);
    chk("f_cur",  32'({cursor_x, cursor_y}), 32'({7'd0, 5'd29}));
    wait_clear(32, 32, "wrap_clr");
    chk("wrap_off_once", 32'(row_offset), 32'd2);

    repeat (5) send(8'h47);
    send(CH_BS);
    @(negedge clkin);
    chk("bs_wr_en", 32'(bus.wr_en),   32'd1);
    chk("bs_addr",  32'(bus.wr_addr), 32'd33);
    chk("bs_be",    32'(bus.wr_be),   32'h1);
    chk("bs_data",  bus.wr_data,      32'h20202020);
    chk("bs_cur_x", 32'(cursor_x),    32'd4);

    send(8'h01);
    @(negedge clkin);
    chk("ctl_nowr",  32'(bus.wr_en), 32'd0);
    chk("ctl_cur_x", 32'(cursor_x),  32'd4);

    send(CH_CR);
    send(CH_BS);
    @(negedge clkin);
    chk("bs0_nowr",  32'(bus.wr_en), 32'd0);
    chk("bs0_cur_x", 32'(cursor_x),  32'd0);

    @(negedge clkin);
    bus.clr_req  = 1'b1;
    bus.ch_valid = 1'b1;
    bus.ch_data  = 8'h48;
    #1 chk("clr_ready", 32'(bus.ch_ready), 32'd0);
    @(posedge clkin);
    #1;
    bus.clr_req  = 1'b0;
    bus.ch_valid = 1'b0;
    @(negedge clkin);
    chk("clr_nowr", 32'(bus.wr_en), 32'd0);
    chk("clr_busy", 32'(busy),      32'd1);
    chk("clr_cur",  32'({cursor_x, cursor_y, row_offset}), 32'd0);

    for (int t = 0; t < 300; t++) begin
      @(negedge clkin);
      if (bus.wr_en && bus.wr_addr == 10'd100) break;
    end
    chk("clr_at100", 32'(bus.wr_addr), 32'd100);
    clrn = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(bus.wr_en),   32'd0);
    chk("mid_rst_addr",  32'(bus.wr_addr), 32'd0);
    chk("mid_rst_busy",  32'(busy),        32'd1);
    chk("mid_rst_ready", 32'(bus.ch_ready),32'd0);
    @(negedge clkin) clrn = 1'b1;
    wait_clear(0, 960, "restart_clr");
    chk("restart_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
